// File: rtl/temp_control_hyst.sv
// temp_control_hyst: greenhouse cooler/heater controller with hysteresis, min-on and lockout.
// Optional run-time alarm is built when TEMP_CTRL_ALARM_EN is defined.
module temp_control_hyst #(
    parameter int W        = 8,
    parameter int HYST     = 5,
    parameter int DEF_COOL = 95,
    parameter int DEF_HEAT = 60,
    parameter int MIN_ON   = 4,
    parameter int MIN_OFF  = 3,
    parameter int MAX_RUN  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] temp,
    input  logic         temp_valid,
    input  logic         cfg_load,
    input  logic [W-1:0] cfg_cool,
    input  logic [W-1:0] cfg_heat,
    output logic         cool_on,
    output logic         heat_on,
    output logic [1:0]   state,
    output logic         cfg_err,
    output logic         alarm
);
    typedef enum logic [1:0] {IDLE = 2'd0, COOL = 2'd1, HEAT = 2'd2, LOCK = 2'd3} state_t;
    localparam int CMAX = MIN_ON > MIN_OFF ? MIN_ON : MIN_OFF;
    localparam int CW   = $clog2(CMAX + 1);
    state_t cur, nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0] cool_th, heat_th;
    logic signed [W:0] t_x, cool_x, heat_x, cool_exit, heat_exit;
    logic signed [W+1:0] ld_heat, ld_cool;
    logic cfg_ok, on_done;
    // one extra bit keeps the hysteresis-shifted thresholds from wrapping
    assign t_x       = {temp[W-1], temp};
    assign cool_x    = {cool_th[W-1], cool_th};
    assign heat_x    = {heat_th[W-1], heat_th};
    assign cool_exit = cool_x - (W+1)'(HYST);
    assign heat_exit = heat_x + (W+1)'(HYST);
    assign ld_heat   = {{2{cfg_heat[W-1]}}, cfg_heat} + (W+2)'(2 * HYST);
    assign ld_cool   = {{2{cfg_cool[W-1]}}, cfg_cool};
    assign cfg_ok    = ld_heat < ld_cool;
    assign on_done   = cnt >= CW'(MIN_ON - 1);
    assign state     = cur;
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    nxt = !(en && temp_valid) ? IDLE : t_x >= cool_x ? COOL : t_x <= heat_x ? HEAT : IDLE;
            COOL:    nxt = !en || (temp_valid && t_x <= cool_exit && on_done) ? LOCK : COOL;
            HEAT:    nxt = !en || (temp_valid && t_x >= heat_exit && on_done) ? LOCK : HEAT;
            LOCK:    nxt = cnt == CW'(MIN_OFF - 1) ? IDLE : LOCK;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= IDLE;
            cnt     <= '0;
            cool_on <= 1'b0;
            heat_on <= 1'b0;
            cfg_err <= 1'b0;
            cool_th <= W'(DEF_COOL);
            heat_th <= W'(DEF_HEAT);
        end else begin
            cur     <= nxt;
            cnt     <= nxt != cur ? '0 : &cnt ? cnt : cnt + CW'(1);
            cool_on <= nxt == COOL;
            heat_on <= nxt == HEAT;
            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_load && cfg_ok) begin
                cool_th <= cfg_cool;
                heat_th <= cfg_heat;
            end
        end
    end
`ifdef TEMP_CTRL_ALARM_EN
    localparam int RW = $clog2(MAX_RUN + 1);
    logic [RW-1:0] run_cnt, run_nxt;
    // run_nxt counts the upcoming cycle, so alarm rises during the MAX_RUN-th active cycle
    assign run_nxt = (nxt == COOL || nxt == HEAT) ? (run_cnt == RW'(MAX_RUN) ? run_cnt : run_cnt + RW'(1)) : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
            alarm   <= 1'b0;
        end else begin
            run_cnt <= run_nxt;
            alarm   <= en && (alarm || run_nxt == RW'(MAX_RUN));
        end
    end
`else
    // always false; MAX_RUN only matters in the alarm build
    assign alarm = MAX_RUN < 0;
`endif
endmodule

// File: tb/tb_temp_control_hyst.sv
// tb_temp_control_hyst: directed scenarios plus randomized traffic against a behavioural model.
module tb_temp_control_hyst;
    localparam int W = 8, HYST = 5, MIN_ON = 4, MIN_OFF = 3, MAX_RUN = 16;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, temp_valid = 1'b0, cfg_load = 1'b0;
    logic [7:0] temp = '0, cfg_cool = '0, cfg_heat = '0;
    logic cool_on, heat_on, cfg_err, alarm;
    logic [1:0] state;
    int n_tests = 0, n_fail = 0;
    int m_mode, m_entry, m_k, m_ct, m_ch, m_run, m_err, m_alarm;

    always #5 clk = ~clk;

    temp_control_hyst #(.W(W), .HYST(HYST), .DEF_COOL(95), .DEF_HEAT(60),
                        .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .MAX_RUN(MAX_RUN)) dut (
        .clk(clk), .rst(rst), .en(en), .temp(temp), .temp_valid(temp_valid),
        .cfg_load(cfg_load), .cfg_cool(cfg_cool), .cfg_heat(cfg_heat),
        .cool_on(cool_on), .heat_on(heat_on), .state(state), .cfg_err(cfg_err), .alarm(alarm)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_entry = 0; m_k = 0; m_ct = 95; m_ch = 60; m_run = 0; m_err = 0; m_alarm = 0;
    endtask

    // mode: 0 idle, 1 cool, 2 heat, 3 lock; age = edges since entering the mode
    task automatic model_edge();
        int nm, age, t, cc, ch;
        t = int'($signed(temp)); cc = int'($signed(cfg_cool)); ch = int'($signed(cfg_heat));
        m_k++;
        age = m_k - m_entry;
        nm = m_mode;
        if (m_mode == 0) begin
            if (en && temp_valid) nm = t >= m_ct ? 1 : t <= m_ch ? 2 : 0;
        end else if (m_mode == 1) begin
            if (!en || (temp_valid && t <= m_ct - HYST && age >= MIN_ON)) nm = 3;
        end else if (m_mode == 2) begin
            if (!en || (temp_valid && t >= m_ch + HYST && age >= MIN_ON)) nm = 3;
        end else if (age >= MIN_OFF) nm = 0;
        m_err = (cfg_load && !(ch + 2 * HYST < cc)) ? 1 : 0;
        if (cfg_load && m_err == 0) begin m_ct = cc; m_ch = ch; end
        m_run = (nm == 1 || nm == 2) ? m_run + 1 : 0;
`ifdef TEMP_CTRL_ALARM_EN
        m_alarm = (en && (m_alarm != 0 || m_run >= MAX_RUN)) ? 1 : 0;
`else
        m_alarm = 0;
`endif
        if (nm != m_mode) begin m_mode = nm; m_entry = m_k; end
    endtask

    task automatic step(input logic e, input logic tv, input int t,
                        input logic cl = 1'b0, input int cc = 0, input int ch = 0);
        en = e; temp_valid = tv; temp = 8'(t); cfg_load = cl; cfg_cool = 8'(cc); cfg_heat = 8'(ch);
        @(posedge clk);
        model_edge();
        #1;
        check("state", 32'(state), 32'(m_mode));
        check("cool_on", 32'(cool_on), 32'(m_mode == 1));
        check("heat_on", 32'(heat_on), 32'(m_mode == 2));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
        check("alarm", 32'(alarm), 32'(m_alarm));
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_cool", 32'(cool_on), 32'd0);
        check("rst_heat", 32'(heat_on), 32'd0);
        model_reset();
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_outs", 32'({cool_on, heat_on, cfg_err, alarm}), 32'd0);
        @(negedge clk) rst = 1'b0;
        // cool entry, min-on hold, exit, lockout
        step(1, 1, 95);
        check("cool_enter", 32'(cool_on), 32'd1);
        repeat (3) step(1, 1, 90);
        check("cool_minon", 32'(state), 32'd1);
        step(1, 1, 90);
        check("cool_exit", 32'(state), 32'd3);
        repeat (2) step(1, 0, 0);
        check("lock_hold", 32'(state), 32'd3);
        step(1, 0, 0);
        check("lock_done", 32'(state), 32'd0);
        // heat with hysteresis edge
        step(1, 1, 60);
        check("heat_enter", 32'(heat_on), 32'd1);
        repeat (3) step(1, 1, 64);
        check("heat_band", 32'(state), 32'd2);
        step(1, 1, 65);
        check("heat_exit", 32'(heat_on), 32'd0);
        repeat (3) step(1, 0, 0);
        // rejected then accepted configuration
        step(1, 0, 0, 1, 70, 65);
        check("cfg_reject", 32'(cfg_err), 32'd1);
        step(1, 1, 95);
        check("cfg_err_pulse", 32'(cfg_err), 32'd0);
        check("old_th_cool", 32'(state), 32'd1);
        repeat (4) step(1, 1, 90);
        repeat (3) step(1, 0, 0);
        step(1, 0, 0, 1, 100, 20);
        check("cfg_accept", 32'(cfg_err), 32'd0);
        step(1, 1, 95);
        check("new_th_idle", 32'(state), 32'd0);
        // async reset mid-cool restores default thresholds
        step(1, 1, 100);
        async_reset();
        step(1, 1, 95);
        check("default_th", 32'(state), 32'd1);
        step(1, 1, 90);
        step(0, 0, 0);
        repeat (3) step(0, 0, 0);
        // en drop in heat bypasses min-on
        step(1, 1, 60);
        step(1, 1, 60);
        step(0, 1, 60);
        check("en_off_lock", 32'(state), 32'd3);
        repeat (2) step(0, 0, 0);
        step(0, 1, 40);
        check("en_off_idle", 32'(state), 32'd0);
        // run-time alarm
        step(1, 1, 100);
        repeat (14) step(1, 1, 100);
        check("alarm_pre", 32'(alarm), 32'd0);
        step(1, 1, 100);
`ifdef TEMP_CTRL_ALARM_EN
        check("alarm_set", 32'(alarm), 32'd1);
`else
        check("alarm_off", 32'(alarm), 32'd0);
`endif
        step(0, 1, 100);
        check("alarm_clr", 32'(alarm), 32'd0);
        repeat (3) step(0, 0, 0);
        // load coinciding with a sample uses the old thresholds
        step(1, 1, 95, 1, 100, 20);
        check("load_same_edge", 32'(state), 32'd1);
        repeat (4) step(1, 1, 90);
        repeat (3) step(1, 0, 0);
        step(1, 0, 0, 1, 95, 60);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            else step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(40, 115)),
                      $urandom_range(0, 29) == 0,
                      $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(40, 127)),
                      $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 110)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
